// File: rtl/logic_slice_sequencer_pkg.sv
// Shared op and state codes for the slice-serial logic sequencer.
package logic_slice_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/logic_slice_sequencer_if.sv
// Start/busy/done handshake plus operand and result bus of the logic sequencer.
interface logic_slice_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] y;
  logic              zero;

  modport master (output start, op, a, b, input busy, done, y, zero);
  modport slave  (input start, op, a, b, output busy, done, y, zero);
endinterface

// File: rtl/logic_slice_sequencer_slice.sv
// Shared combinational slice unit; no dependence between bit positions.
module slice_logic_unit
  import logic_slice_sequencer_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] sa,
  input  logic [SLICE_W-1:0] sb,
  input  op_e                op,
  output logic [SLICE_W-1:0] sy
);

  always_comb begin
    sy = '0;
    case (op)
      OP_AND:  sy = sa & sb;
      OP_OR:   sy = sa | sb;
      OP_XOR:  sy = sa ^ sb;
      OP_NOR:  sy = ~(sa | sb);
      default: sy = '0;
    endcase
  end

endmodule

// File: rtl/logic_slice_sequencer.sv
// Slice-serial bitwise logic controller: one SLICE_W unit reused LSB slice first.
//   state   | meaning
//   IDLE    | waiting for start, result held
//   RUN     | one slice computed and written per clock
//   DONE    | result final, done pulse for one cycle
module logic_slice_sequencer
  import logic_slice_sequencer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  logic_slice_sequencer_if.slave  bus
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] a_q, b_q, y_q, y_d;
  op_e               op_q;
  logic              busy_q, done_q, zero_q;
  logic [SLICE_W-1:0] sa, sb, sy;

  always_comb begin
    sa = a_q[int'(cnt_q)*SLICE_W +: SLICE_W];
    sb = b_q[int'(cnt_q)*SLICE_W +: SLICE_W];
    y_d = y_q;
    y_d[int'(cnt_q)*SLICE_W +: SLICE_W] = sy;
  end

  slice_logic_unit #(.SLICE_W(SLICE_W)) u_slice (
    .sa (sa),
    .sb (sb),
    .op (op_q),
    .sy (sy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      y_q     <= '0;
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= op_e'(bus.op);
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          y_q <= y_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            zero_q  <= (y_d == '0);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_logic_slice_sequencer.sv
// Scoreboarded bench for logic_slice_sequencer: directed cases plus randomized ops.
module tb_logic_slice_sequencer;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 4;
  localparam int NSLICE  = DATA_W / SLICE_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_slice_sequencer_if #(.DATA_W(DATA_W)) bus ();

  logic_slice_sequencer #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [DATA_W:0] exp_q[$];
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [DATA_W-1:0] ref_op(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        logic [DATA_W:0] e;
        check("done_one_cycle", 64'(prev_done), 64'd0);
        check("busy_with_done", 64'(bus.busy), 64'd1);
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("y_result", 64'(bus.y), 64'(e[DATA_W:1]));
          check("zero_flag", 64'(bus.zero), 64'(e[0]));
        end
      end
      prev_done = bus.done;
    end
  end

  function automatic logic [DATA_W:0] expect_of(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [1:0] op);
    logic [DATA_W-1:0] r;
    r = ref_op(a, b, op);
    return {r, (r == '0)};
  endfunction

  task automatic wait_idle();
    int w = 0;
    while (bus.busy && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check("idle_before_start", 64'(bus.busy), 64'd0);
  endtask

  task automatic run_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [1:0] op, input bit perturb);
    int cycles;
    logic [DATA_W-1:0] r;
    r = ref_op(a, b, op);
    @(posedge clk); #1;
    wait_idle();
    bus.a = a; bus.b = b; bus.op = op; bus.start = 1'b1;
    exp_q.push_back(expect_of(a, b, op));
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("no_done_at_start", 64'(bus.done), 64'd0);
    cycles = 0;
    while (!bus.done && cycles < NSLICE + 6) begin
      if (perturb && cycles == 2) begin
        bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom_range(0, 3));
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    bus.start = 1'b0;
    check("done_latency", 64'(cycles), 64'(NSLICE));
    @(posedge clk); #1;
    check("idle_after_done", 64'(bus.busy), 64'd0);
    check("done_dropped", 64'(bus.done), 64'd0);
    check("y_held", 64'(bus.y), 64'(r));
  endtask

  initial begin
    int last_acc;
    int w;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op = 2'd0;
    rst_n = 1'b0;
    #23;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_y", 64'(bus.y), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd1);
    @(negedge clk); rst_n = 1'b1;

    run_op(32'hFFFF0000, 32'h0F0F0F0F, 2'd0, 1'b0);
    run_op(32'h12345678, 32'hF0F0F0F0, 2'd1, 1'b0);
    run_op(32'h12345678, 32'hF0F0F0F0, 2'd2, 1'b0);
    run_op(32'h12345678, 32'hF0F0F0F0, 2'd3, 1'b0);
    run_op(32'h12345678, 32'hF0F0F0F0, 2'd0, 1'b0);
    run_op(32'hAAAAAAAA, 32'h55555555, 2'd0, 1'b0);
    run_op(32'h00000000, 32'h00000000, 2'd2, 1'b1);
    for (int i = 0; i < 12; i++)
      run_op($urandom, $urandom, 2'($urandom_range(0, 3)), i[0]);

    // Asynchronous reset landing between edges mid-operation
    @(posedge clk); #1;
    wait_idle();
    bus.a = 32'h0F0F0F0F; bus.b = 32'hFFFFFFFF; bus.op = 2'd1; bus.start = 1'b1;
    exp_q.push_back(expect_of(bus.a, bus.b, bus.op));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_y", 64'(bus.y), 64'd0);
    check("midrst_zero", 64'(bus.zero), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 1'b0);

    // Back-to-back with start held high
    @(posedge clk); #1;
    last_acc = 0;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (bus.busy && w < 30) begin
        @(posedge clk); #1;
        w++;
      end
      check("b2b_idle_reached", 64'(bus.busy), 64'd0);
      bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom_range(0, 3));
      bus.start = 1'b1;
      exp_q.push_back(expect_of(bus.a, bus.b, bus.op));
      if (k > 0) check("b2b_period", 64'(cyc - last_acc), 64'(NSLICE + 2));
      last_acc = cyc;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;

    w = 0;
    while (exp_q.size() != 0 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
